// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 host loader/unloader.
package aes_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

  typedef enum logic [2:0] {
    StIdle,
    StLoadKey,
    StLoadData,
    StStart,
    StWait,
    StDrain
  } host_state_t;

  // Word 0 is the most significant word of the block.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         idx);
    logic [WORD_W-1:0] w;
    unique case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_word_assembler.sv
// 4x32 serial-in/parallel-out block register; the first word shifted in ends up at the top.
module aes_word_assembler
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [WORD_W-1:0]  word_i,
  output logic [BLOCK_W-1:0] block_o
);

  logic [BLOCK_W-1:0] block_q, block_d;

  always_comb begin
    block_d = block_q;
    if (clr_i) begin
      block_d = '0;
    end else if (load_i) begin
      block_d = {block_q[BLOCK_W-WORD_W-1:0], word_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_q <= '0;
    end else begin
      block_q <= block_d;
    end
  end

  assign block_o = block_q;

endmodule

// File: rtl/aes_host_if.sv
// Host-side command/word-stream front end for the AES-128 core: loads key and data,
// kicks the core, waits for completion (with timeout) and unloads the result.
module aes_host_if
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_encrypt,
  input  logic               cmd_new_key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic [BLOCK_W-1:0] key_o,
  output logic [BLOCK_W-1:0] data_o,
  output logic               start,
  output logic               keyChange,
  output logic               selCypher,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               busy,
  output logic               err
);

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES - 1);

  host_state_t        state_q;
  logic [1:0]         word_cnt_q;
  logic [7:0]         to_cnt_q;
  logic               key_loaded_q;
  logic               err_q;
  logic               key_change_q;
  logic               sel_cypher_q;
  logic [BLOCK_W-1:0] result_q;

  logic cmd_hs, in_hs, out_hs;

  assign cmd_ready = (state_q == StIdle);
  assign in_ready  = (state_q == StLoadKey) || (state_q == StLoadData);
  assign out_valid = (state_q == StDrain);
  assign start     = (state_q == StStart);
  assign busy      = (state_q != StIdle);
  assign err       = err_q;
  assign keyChange = key_change_q;
  assign selCypher = sel_cypher_q;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // The key is only wiped by a command that brings a new one; data is wiped on every accept.
  aes_word_assembler u_key_asm (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cmd_hs & cmd_new_key),
    .load_i  (in_hs & (state_q == StLoadKey)),
    .word_i  (in_data),
    .block_o (key_o)
  );

  aes_word_assembler u_data_asm (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cmd_hs),
    .load_i  (in_hs & (state_q == StLoadData)),
    .word_i  (in_data),
    .block_o (data_o)
  );

  always_comb begin
    out_data = '0;
    if (state_q == StDrain) begin
      out_data = block_word(result_q, word_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      word_cnt_q   <= 2'd0;
      to_cnt_q     <= 8'd0;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
      key_change_q <= 1'b0;
      sel_cypher_q <= 1'b0;
      result_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            sel_cypher_q <= cmd_encrypt;
            key_change_q <= cmd_new_key;
            err_q        <= 1'b0;
            word_cnt_q   <= 2'd0;
            if (cmd_new_key) begin
              state_q <= StLoadKey;
            end else if (key_loaded_q) begin
              state_q <= StLoadData;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StLoadKey: begin
          if (in_hs) begin
            word_cnt_q <= word_cnt_q + 2'd1;
            if (word_cnt_q == 2'd3) begin
              key_loaded_q <= 1'b1;
              state_q      <= StLoadData;
            end
          end
        end
        StLoadData: begin
          if (in_hs) begin
            word_cnt_q <= word_cnt_q + 2'd1;
            if (word_cnt_q == 2'd3) begin
              state_q <= StStart;
            end
          end
        end
        StStart: begin
          to_cnt_q <= 8'd0;
          state_q  <= StWait;
        end
        StWait: begin
          // A completion in the limit cycle still counts as success.
          if (core_done) begin
            result_q   <= core_result;
            word_cnt_q <= 2'd0;
            state_q    <= StDrain;
          end else if (to_cnt_q == TimeoutLimit) begin
            err_q        <= 1'b1;
            key_loaded_q <= 1'b0;
            key_change_q <= 1'b0;
            state_q      <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        StDrain: begin
          if (out_hs) begin
            word_cnt_q <= word_cnt_q + 2'd1;
            if (word_cnt_q == 2'd3) begin
              key_change_q <= 1'b0;
              state_q      <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_if.sv
// Directed bench for aes_host_if with a tiny lookup-based core model.
module tb_aes_host_if;

  localparam int unsigned TimeoutCycles = 64;

  localparam logic [127:0] Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Bad = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_encrypt = 1'b0;
  logic         cmd_new_key = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [127:0] key_o;
  logic [127:0] data_o;
  logic         start;
  logic         keyChange;
  logic         selCypher;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  // Core model state
  logic         core_en = 1'b1;
  int           spur_req = 0;
  int           spur_seen = 0;
  int           pend = 0;
  logic [127:0] res_next = '0;
  int           start_cnt = 0;
  logic         kc_at_start = 1'b0;
  logic         sc_at_start = 1'b0;
  logic [127:0] key_at_start = '0;
  logic [127:0] data_at_start = '0;

  aes_host_if #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_encrypt (cmd_encrypt),
    .cmd_new_key (cmd_new_key),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .key_o       (key_o),
    .data_o      (data_o),
    .start       (start),
    .keyChange   (keyChange),
    .selCypher   (selCypher),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Core model: answers three cycles after a start pulse, from a known-vector table.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (spur_req != spur_seen) begin
      spur_seen   = spur_req;
      core_done   = 1'b1;
      core_result = Bad;
    end else if (pend != 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        core_done   = 1'b1;
        core_result = res_next;
      end
    end
    if (start) begin
      start_cnt     = start_cnt + 1;
      kc_at_start   = keyChange;
      sc_at_start   = selCypher;
      key_at_start  = key_o;
      data_at_start = data_o;
      if (core_en) begin
        pend = 3;
        if (selCypher && key_o == Key && data_o == Pt) res_next = Ct;
        else if (!selCypher && key_o == Key && data_o == Ct) res_next = Pt;
        else res_next = Bad;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic enc, input logic new_key);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 1'b0, 1'b1);
    cmd_valid   = 1'b1;
    cmd_encrypt = enc;
    cmd_new_key = new_key;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Sends words [0, nwords) of blk; optionally injects a spurious core_done after word spur_at.
  task automatic send_block(input logic [127:0] blk, input int max_gap, input int nwords,
                            input int spur_at);
    for (int i = 0; i < nwords; i++) begin
      int n = 0;
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = blk[(3-i)*32 +: 32];
      while (!in_ready && n < 200) begin
        tick();
        n++;
      end
      if (!in_ready) begin
        check("in_ready_wait", 1'b0, 1'b1);
        in_valid = 1'b0;
        return;
      end
      tick();
      in_valid = 1'b0;
      if (i == spur_at) spur_req++;
    end
  endtask

  task automatic recv_block(input string tag, input logic [127:0] exp, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      while (!out_valid && n < 300) begin
        tick();
        n++;
      end
      if (!out_valid) begin
        check($sformatf("%s_out_valid_wait", tag), 1'b0, 1'b1);
        return;
      end
      repeat (gap) tick();
      check($sformatf("%s_w%0d", tag, i), out_data, exp[(3-i)*32 +: 32]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int s0;
    int n;

    // Reset state
    repeat (2) tick();
    check("rst_key", key_o, '0);
    check("rst_data", data_o, '0);
    check("rst_out_data", out_data, '0);
    check("rst_flags", {keyChange, selCypher, start, err, busy, in_ready, out_valid}, '0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    reset = 1'b0;
    tick();

    // Encrypt with a new key
    s0 = start_cnt;
    send_cmd(1'b1, 1'b1);
    check("accept_in_ready", in_ready, 1'b1);
    send_block(Key, 0, 4, -1);
    send_block(Pt, 0, 4, -1);
    check("start_latency", start, 1'b1);
    tick();
    check("start_one_cycle", start, 1'b0);
    recv_block("enc", Ct, 0);
    check("enc_starts", 32'(start_cnt - s0), 32'd1);
    check("enc_kc", kc_at_start, 1'b1);
    check("enc_sc", sc_at_start, 1'b1);
    check("enc_key", key_at_start, Key);
    check("enc_data", data_at_start, Pt);
    check("enc_end", {busy, keyChange, err}, 3'b000);
    check("enc_key_hold", key_o, Key);

    // Decrypt reusing the key
    s0 = start_cnt;
    send_cmd(1'b0, 1'b0);
    send_block(Ct, 0, 4, -1);
    recv_block("dec", Pt, 0);
    check("dec_starts", 32'(start_cnt - s0), 32'd1);
    check("dec_kc_sc", {kc_at_start, sc_at_start}, 2'b00);
    check("dec_data", data_at_start, Ct);

    // No key after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    s0 = start_cnt;
    send_cmd(1'b1, 1'b0);
    check("nokey_err", err, 1'b1);
    check("nokey_busy", busy, 1'b0);
    check("nokey_cmd_ready", cmd_ready, 1'b1);
    repeat (5) tick();
    check("nokey_starts", 32'(start_cnt - s0), 32'd0);

    // Timeout: the core never answers
    core_en = 1'b0;
    send_cmd(1'b1, 1'b1);
    check("err_cleared", err, 1'b0);
    send_block(Key, 0, 4, -1);
    send_block(Pt, 0, 4, -1);
    n = 0;
    while (!err && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TimeoutCycles + 1));
    check("timeout_busy", busy, 1'b0);
    core_en = 1'b1;
    send_cmd(1'b1, 1'b0);
    check("timeout_needs_key", {err, busy}, 2'b10);

    // Random gaps with a spurious core_done during LOAD_DATA
    s0 = start_cnt;
    send_cmd(1'b1, 1'b1);
    send_block(Key, 3, 4, -1);
    send_block(Pt, 3, 4, 1);
    recv_block("gap", Ct, 3);
    check("gap_starts", 32'(start_cnt - s0), 32'd1);
    check("gap_err", err, 1'b0);

    // Reset during the third data word
    send_cmd(1'b1, 1'b1);
    send_block(Key, 0, 4, -1);
    send_block(Pt, 0, 2, -1);
    in_valid = 1'b1;
    in_data  = Pt[63:32];
    #2;
    reset = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_rst_blocks", {key_o, data_o}, '0);
    check("mid_rst_flags", {keyChange, selCypher, start, err, busy, out_valid}, '0);
    check("mid_rst_out_data", out_data, '0);
    reset = 1'b0;
    tick();
    send_cmd(1'b1, 1'b0);
    check("mid_rst_key_lost", err, 1'b1);
    s0 = start_cnt;
    send_cmd(1'b1, 1'b1);
    send_block(Key, 1, 4, -1);
    send_block(Pt, 1, 4, -1);
    recv_block("fresh", Ct, 1);
    check("fresh_starts", 32'(start_cnt - s0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_host_if.md
# aes_host_if

Host-side loader/unloader for the AES-128 core. Accepts a command plus a 32-bit word stream over valid/ready, assembles the 128-bit key and data blocks, drives the control FSM's `start`/`keyChange`/`selCypher` inputs, waits for the core's completion pulse, then returns the 128-bit result as four 32-bit words. Sits directly upstream and downstream of the core's control FSM and datapath.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum number of cycles in WAIT before abort; range 16..255.
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both high; high only in IDLE
- `cmd_encrypt`  in  1  1 = encrypt, 0 = decrypt; sampled on command accept
- `cmd_new_key`  in  1  1 = four key words precede the data words
- `in_valid`  in  1  input word offered
- `in_ready`  out  1  high only in LOAD_KEY / LOAD_DATA
- `in_data`  in  32  input word, MSB word first
- `key_o`  out  128  assembled key to core
- `data_o`  out  128  assembled plaintext/ciphertext to core
- `start`  out  1  one-cycle pulse to core FSM
- `keyChange`  out  1  to core FSM
- `selCypher`  out  1  to core FSM
- `core_done`  in  1  one-cycle pulse from core when its output register loads
- `core_result`  in  128  core output block, valid when `core_done` is high
- `out_valid`  out  1  result word offered
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  32  result word, MSB word first
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky error; cleared on next accepted command

## Operation
- States: IDLE, LOAD_KEY, LOAD_DATA, START, WAIT, DRAIN.
- IDLE: `cmd_ready`=1. On accept: latch `cmd_encrypt` into `selCypher`, `cmd_new_key` into `keyChange`, clear `err`, word counter = 0. Go to LOAD_KEY if new_key, else LOAD_DATA if `key_loaded`=1. If new_key=0 and `key_loaded`=0: set `err`, remain in IDLE.
- LOAD_KEY / LOAD_DATA: each in handshake shifts `in_data` into the target register; word 0 lands in [127:96], word 3 in [31:0]. 2-bit counter wraps 3->0 on the fourth word; LOAD_KEY then goes to LOAD_DATA and sets `key_loaded`; LOAD_DATA goes to START.
- START: `start`=1 for exactly one cycle; next state WAIT, timeout counter cleared.
- WAIT: on `core_done`, capture `core_result`, go to DRAIN. If counter reaches TIMEOUT_CYCLES-1 without `core_done`: set `err`, clear `key_loaded`, go to IDLE.
- DRAIN: `out_data` = captured word selected by counter; advance on each out handshake; after the fourth word go to IDLE and drop `keyChange` to 0.
- `keyChange` and `selCypher` are held stable from command accept until return to IDLE.
- `core_done` outside WAIT is ignored.

## Timing
- Reset values: all outputs 0 (`key_o`, `data_o`, `out_data` = 0; `keyChange`, `selCypher`, `start`, `err`, `busy` = 0); state IDLE; `key_loaded` = 0.
- Reset mid-operation: immediate return to IDLE; any partially loaded block is discarded and `key_loaded` is cleared.
- Command accept -> first `in_ready` high: 1 cycle.
- Last data word accepted -> `start` high: 1 cycle. `start` high -> WAIT: 1 cycle.
- `core_done` -> `out_valid` high: 1 cycle. At most one word per cycle in and out; stalls of any length on `in_valid` or `out_ready` are legal.
- `key_o` and `data_o` are stable from START until the next command accept.
- `core_done` arriving in the same cycle as the timeout limit: done wins, `err` stays 0.

## Structure
- `aes_pkg`: state enum `host_state_t`, `WORDS_PER_BLOCK` = 4, `WORD_W` = 32.
- Sub-module `aes_word_assembler`: 4x32 serial-in/parallel-out register with load-enable and clear, instantiated twice, once for key and once for data. The output unload uses a mux on the captured result.

## Test plan
- Encrypt, new key: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> one-cycle `start` pulse with `keyChange`=1 and `selCypher`=1; out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- Decrypt, reusing the loaded key: ct 69c4e0d8...70b4c55a with `cmd_new_key`=0 -> `keyChange`=0, `selCypher`=0; result 00112233...eeff.
- Command with `cmd_new_key`=0 after reset -> `err`=1, `busy`=0, `cmd_ready` stays 1, no `start` pulse.
- Core model never pulses `core_done` -> `err`=1 exactly TIMEOUT_CYCLES cycles after entering WAIT; the next command then requires a new key.
- Random `in_valid` and `out_ready` gaps, plus a spurious `core_done` during LOAD_DATA -> result unchanged and exactly one `start` pulse.
- Reset asserted during the third data word -> all outputs 0 next cycle; a fresh command completes correctly.
